alu_reg_seq: RTL and testbench
==============================

ALU_REG_SEQ -- requirements
Module: alu_reg_seq

Interface
REQ-001 Parameter: none; data width fixed at 32, register address width 5, op width 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one register-to-register ALU operation; sampled only in IDLE.
REQ-005 op  input  3  ALU function code: 000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 set-less-than, 111 shift B right by A.
REQ-006 rs, rt, rd  input  5 each  source A, source B, destination register addresses.
REQ-007 ra_addr, rb_addr  output  5 each  register-file read addresses; read data returns combinationally.
REQ-008 ra_data, rb_data  input  32 each  register-file read data.
REQ-009 w_addr  output  5,  w_data  output  32,  we  output  1  register-file write port.
REQ-010 alu_a, alu_b  output  32 each,  alu_op  output  3  ALU operand and function drive.
REQ-011 alu_f  input  32,  alu_zf  input  1,  alu_of  input  1  ALU result and flags (combinational ALU).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on completion.
REQ-014 zf, of  output  1 each  registered flags of the last completed operation.
REQ-015 wb_skip  output  1  registered; high if the last operation's write-back was suppressed.

Function
REQ-016 FSM states: IDLE, READ, EXEC, WB, DONE; the FSM steps through READ, EXEC, WB and DONE one cycle each, unconditionally.
REQ-017 IDLE: on start=1, latch op, rs, rt and rd into internal registers and go to READ; otherwise stay in IDLE.
REQ-018 start, op and address inputs are ignored outside IDLE; changes after the capture edge do not affect the operation in progress.
REQ-019 READ: ra_addr=latched rs, rb_addr=latched rt; at the end of the cycle, latch ra_data and rb_data into operand registers A and B.
REQ-020 EXEC: alu_a=A, alu_b=B, alu_op=latched op; at the end of the cycle, latch alu_f into result R and alu_zf and alu_of into zf and of.
REQ-021 WB: we=1, w_addr=latched rd, w_data=R, unless suppressed.
REQ-022 Write-back is suppressed (we=0) when rd=0, or when of=1 with op=100 or op=101; wb_skip reflects the suppression and is set at the end of the WB cycle.
REQ-023 DONE: done=1 for exactly one cycle, then go to IDLE; start is not accepted in DONE.
REQ-024 Latency: start accepted at edge N, so the write occurs in cycle N+3 and done is high in cycle N+4; the earliest next accept is at edge N+5.
REQ-025 Outside their active states: ra_addr, rb_addr, w_addr, alu_op=0; alu_a, alu_b, w_data=0; we=0.
REQ-026 zf, of and wb_skip hold their values until the next operation updates them.
REQ-027 Read-after-write: an operation whose rs or rt equals the previous operation's rd observes the written value.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE; A, B, R, zf, of, wb_skip, done, we and all latched fields=0.
REQ-029 Reset has priority over start.
REQ-030 Reset in any state, including WB, aborts the operation; no write occurs in the cycle after the reset edge, and done does not pulse.

Verification
REQ-031 Setup: r1=5, r2=3; start with op=100, rs=1, rt=2, rd=3 -> we=1, w_addr=3, w_data=8 in cycle N+3; done in N+4; zf=0, of=0, wb_skip=0.
REQ-032 Setup: r1=r2=0x7FFFFFFF; op=100, rd=4 -> of=1, we stays 0, wb_skip=1, done pulses, r4 unchanged.
REQ-033 Setup: r1=7, r2=7; op=101, rd=0 -> R=0, zf=1, no write (rd=0), wb_skip=1.
REQ-034 Hold start=1 continuously with op=110 on r5=2, r6=9, rd=7 -> one operation per 5 cycles, r7=1, busy low for exactly one cycle between operations.
REQ-035 Assert rst during the WB cycle -> no write to rd, done stays 0, busy=0 next cycle, all flags=0.
REQ-036 Back-to-back: operation 1 writes r3=8; operation 2 with op=111, rs=1 (=5), rt=3 -> r_dest=0 (8>>5), zf=1.

Source files
------------

// File: rtl/alu_reg_seq.sv
// Sequencer for one register-to-register ALU operation: read the two sources,
// execute on an external ALU, write the result back, then pulse done.
module alu_reg_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    output logic [4:0]  ra_addr,
    output logic [4:0]  rb_addr,
    input  logic [31:0] ra_data,
    input  logic [31:0] rb_data,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic        we,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_f,
    input  logic        alu_zf,
    input  logic        alu_of,
    output logic        busy,
    output logic        done,
    output logic        zf,
    output logic        of,
    output logic        wb_skip
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  ra_addr_q;
    logic [4:0]  rb_addr_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [2:0]  alu_op_q;
    logic [4:0]  w_addr_q;
    logic [31:0] w_data_q;
    logic        we_q;
    logic        skip_q;
    logic        busy_q;
    logic        done_q;
    logic        zf_q;
    logic        of_q;
    logic        wb_skip_q;
    logic        skip_d;

    // Write-back is dropped for r0 and for signed overflow on add/sub.
    always_comb begin
        skip_d = (rd_q == 5'd0) ||
                 (alu_of && ((op_q == 3'b100) || (op_q == 3'b101)));
    end

    // Sequencer state and registered output drive; the operand registers A/B
    // are the ALU drive registers and are cleared once EXEC is over.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            rd_q      <= 5'd0;
            ra_addr_q <= 5'd0;
            rb_addr_q <= 5'd0;
            alu_a_q   <= 32'd0;
            alu_b_q   <= 32'd0;
            alu_op_q  <= 3'd0;
            w_addr_q  <= 5'd0;
            w_data_q  <= 32'd0;
            we_q      <= 1'b0;
            skip_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            wb_skip_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        rd_q      <= rd;
                        ra_addr_q <= rs;
                        rb_addr_q <= rt;
                        busy_q    <= 1'b1;
                        state_q   <= S_READ;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end
                S_READ: begin
                    ra_addr_q <= 5'd0;
                    rb_addr_q <= 5'd0;
                    alu_a_q   <= ra_data;
                    alu_b_q   <= rb_data;
                    alu_op_q  <= op_q;
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    alu_a_q   <= 32'd0;
                    alu_b_q   <= 32'd0;
                    alu_op_q  <= 3'd0;
                    w_data_q  <= alu_f;
                    w_addr_q  <= rd_q;
                    zf_q      <= alu_zf;
                    of_q      <= alu_of;
                    skip_q    <= skip_d;
                    we_q      <= ~skip_d;
                    state_q   <= S_WB;
                end
                S_WB: begin
                    w_addr_q  <= 5'd0;
                    w_data_q  <= 32'd0;
                    we_q      <= 1'b0;
                    wb_skip_q <= skip_q;
                    done_q    <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    we_q      <= 1'b0;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign ra_addr = ra_addr_q;
    assign rb_addr = rb_addr_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_op  = alu_op_q;
    assign w_addr  = w_addr_q;
    assign w_data  = w_data_q;
    // A reset raised during WB must also stop the write landing at that edge.
    assign we      = we_q & ~rst;
    assign busy    = busy_q;
    assign done    = done_q;
    assign zf      = zf_q;
    assign of      = of_q;
    assign wb_skip = wb_skip_q;

endmodule

// File: tb/tb_alu_reg_seq.sv
// Directed bench for alu_reg_seq with a behavioural register file and ALU.
module tb_alu_reg_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  ra_addr, rb_addr, w_addr;
    logic [31:0] ra_data, rb_data, w_data;
    logic        we;
    logic [31:0] alu_a, alu_b, alu_f;
    logic [2:0]  alu_op;
    logic        alu_zf, alu_of;
    logic        busy, done, zf, of, wb_skip;

    logic [31:0] rf [0:31];
    logic        tb_we;
    logic [4:0]  tb_addr;
    logic [31:0] tb_data;
    logic [31:0] m_res;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_reg_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs(rs), .rt(rt), .rd(rd),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .w_addr(w_addr), .w_data(w_data), .we(we),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
        .busy(busy), .done(done), .zf(zf), .of(of), .wb_skip(wb_skip)
    );

    assign ra_data = (ra_addr == 5'd0) ? 32'd0 : rf[ra_addr];
    assign rb_data = (rb_addr == 5'd0) ? 32'd0 : rf[rb_addr];

    // Register file write port; bench preloads share the port while the DUT is idle.
    always @(posedge clk) begin
        if (we) rf[w_addr] <= w_data;
        else if (tb_we) rf[tb_addr] <= tb_data;
    end

    // Combinational ALU model.
    always_comb begin
        m_res  = 32'd0;
        alu_of = 1'b0;
        case (alu_op)
            3'b000: m_res = alu_a & alu_b;
            3'b001: m_res = alu_a | alu_b;
            3'b010: m_res = alu_a ^ alu_b;
            3'b011: m_res = ~(alu_a | alu_b);
            3'b100: begin
                m_res  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            3'b101: begin
                m_res  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            3'b110: m_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: m_res = alu_b >> alu_a[4:0];
        endcase
        alu_f  = m_res;
        alu_zf = (m_res == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        start = 1'b1; op = o; rs = s; rt = t; rd = d;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 3'b100; rs = 5'd1; rt = 5'd2; rd = 5'd3;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", we); end
        checks++; if ({zf, of, wb_skip} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {zf, of, wb_skip}); end
        checks++; if ({ra_addr, rb_addr, w_addr, alu_op} !== 18'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", {ra_addr, rb_addr, w_addr, alu_op}); end
        start = 1'b0; rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got %0b want 0", busy); end
    endtask

    task automatic test_add();
        preload(5'd1, 32'd5); preload(5'd2, 32'd3); preload(5'd3, 32'd0);
        issue(3'b100, 5'd1, 5'd2, 5'd3);
        op = 3'b010; rs = 5'd10; rt = 5'd11; rd = 5'd12;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %0b want 1", busy); end
        checks++; if ({ra_addr, rb_addr} !== {5'd1, 5'd2}) begin errors++; $display("FAIL add_read_addr: got %0d/%0d want 1/2", ra_addr, rb_addr); end
        tick();
        checks++; if ({alu_a, alu_b} !== {32'd5, 32'd3}) begin errors++; $display("FAIL add_operands: got %0d/%0d want 5/3", alu_a, alu_b); end
        checks++; if (alu_op !== 3'b100) begin errors++; $display("FAIL add_alu_op: got %b want 100", alu_op); end
        checks++; if (ra_addr !== 5'd0) begin errors++; $display("FAIL add_ra_cleared: got %0d want 0", ra_addr); end
        tick();
        checks++; if ({we, w_addr, w_data} !== {1'b1, 5'd3, 32'd8}) begin errors++; $display("FAIL add_wb: got we=%0b addr=%0d data=%0d want 1/3/8", we, w_addr, w_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_early: got %0b want 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done: got %0b want 1", done); end
        checks++; if (rf[3] !== 32'd8) begin errors++; $display("FAIL add_r3: got %0d want 8", rf[3]); end
        checks++; if ({zf, of, wb_skip, we} !== 4'b0000) begin errors++; $display("FAIL add_flags: got %b want 0000", {zf, of, wb_skip, we}); end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL add_idle: got %b want 00", {busy, done}); end
    endtask

    task automatic test_logic();
        logic [2:0]  ops [4]  = '{3'b000, 3'b001, 3'b010, 3'b011};
        logic [31:0] exp [4]  = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F};
        preload(5'd10, 32'hF0F0_F0F0); preload(5'd11, 32'hFF00_FF00);
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 5'd10, 5'd11, 5'd12);
            tick(); tick(); tick();
            checks++; if (rf[12] !== exp[i]) begin errors++; $display("FAIL logic_op%0d: got %h want %h", i, rf[12], exp[i]); end
            tick();
        end
    endtask

    task automatic test_overflow();
        preload(5'd1, 32'h7FFF_FFFF); preload(5'd2, 32'h7FFF_FFFF); preload(5'd4, 32'h0000_A5A5);
        issue(3'b100, 5'd1, 5'd2, 5'd4);
        tick(); tick();
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL ovf_we: got %0b want 0", we); end
        tick();
        checks++; if ({done, of, wb_skip} !== 3'b111) begin errors++; $display("FAIL ovf_flags: got %b want 111", {done, of, wb_skip}); end
        checks++; if (rf[4] !== 32'h0000_A5A5) begin errors++; $display("FAIL ovf_r4: got %h want 0000a5a5", rf[4]); end
        tick();
    endtask

    task automatic test_sub_zero();
        preload(5'd1, 32'd7); preload(5'd2, 32'd7);
        issue(3'b101, 5'd1, 5'd2, 5'd0);
        tick(); tick();
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL subz_we: got %0b want 0", we); end
        tick();
        checks++; if ({done, zf, of, wb_skip} !== 4'b1101) begin errors++; $display("FAIL subz_flags: got %b want 1101", {done, zf, of, wb_skip}); end
        tick();
    endtask

    task automatic test_reset_in_wb();
        preload(5'd1, 32'd5); preload(5'd2, 32'd5); preload(5'd8, 32'h0000_1234);
        issue(3'b101, 5'd1, 5'd2, 5'd8);
        tick(); tick();
        checks++; if ({we, zf} !== 2'b11) begin errors++; $display("FAIL rstwb_pre: got %b want 11", {we, zf}); end
        rst = 1'b1;
        #1;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rstwb_we_gate: got %0b want 0", we); end
        tick();
        rst = 1'b0;
        checks++; if ({busy, done, we} !== 3'b000) begin errors++; $display("FAIL rstwb_state: got %b want 000", {busy, done, we}); end
        checks++; if ({zf, of, wb_skip} !== 3'b000) begin errors++; $display("FAIL rstwb_flags: got %b want 000", {zf, of, wb_skip}); end
        checks++; if (rf[8] !== 32'h0000_1234) begin errors++; $display("FAIL rstwb_r8: got %h want 00001234", rf[8]); end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstwb_after: got %b want 00", {busy, done}); end
    endtask

    task automatic test_hold_start();
        preload(5'd5, 32'd2); preload(5'd6, 32'd9); preload(5'd7, 32'd0);
        start = 1'b1; op = 3'b110; rs = 5'd5; rt = 5'd6; rd = 5'd7;
        for (int i = 0; i < 10; i++) begin
            logic eb, ed;
            tick();
            eb = (i % 5) != 4;
            ed = (i % 5) == 3;
            checks++; if ({busy, done} !== {eb, ed}) begin errors++; $display("FAIL hold_cycle%0d: got %b want %b", i, {busy, done}, {eb, ed}); end
        end
        start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_stop: got %0b want 0", busy); end
        checks++; if (rf[7] !== 32'd1) begin errors++; $display("FAIL hold_r7: got %0d want 1", rf[7]); end
    endtask

    task automatic test_back_to_back();
        preload(5'd1, 32'd5); preload(5'd2, 32'd3); preload(5'd3, 32'd0); preload(5'd9, 32'h0000_FFFF);
        issue(3'b100, 5'd1, 5'd2, 5'd3);
        tick(); tick();
        start = 1'b1; op = 3'b111; rs = 5'd1; rt = 5'd3; rd = 5'd9;
        tick();
        checks++; if (rf[3] !== 32'd8) begin errors++; $display("FAIL b2b_r3: got %0d want 8", rf[3]); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done_accept: got %0b want 0", busy); end
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %0b want 1", busy); end
        tick(); tick(); tick();
        checks++; if (rf[9] !== 32'd0) begin errors++; $display("FAIL b2b_r9: got %h want 0", rf[9]); end
        checks++; if ({done, zf, wb_skip} !== 3'b110) begin errors++; $display("FAIL b2b_flags: got %b want 110", {done, zf, wb_skip}); end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        tb_we = 1'b0; tb_addr = 5'd0; tb_data = 32'd0;
        test_reset();
        test_add();
        test_logic();
        test_overflow();
        test_sub_zero();
        test_reset_in_wb();
        test_hold_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
